// File: rtl/midi_poly_pkg.sv
// Shared MIDI constants, parser state encoding and message-length helper
// for the polyphonic note allocator.
package midi_poly_pkg;

  localparam logic [3:0] NOTE_OFF  = 4'h8;
  localparam logic [3:0] NOTE_ON   = 4'h9;
  localparam logic [3:0] CC        = 4'hB;
  localparam logic [3:0] PROG      = 4'hC;
  localparam logic [3:0] CHAN_PRES = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    D1   = 2'd1,
    D2   = 2'd2
  } parse_state_t;

  // Number of data bytes that follow a channel status nibble.
  function automatic logic [1:0] msg_len(input logic [3:0] hi);
    return (hi == PROG || hi == CHAN_PRES) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_poly_voice_lru.sv
// Least-recently-used ordering of voice slots; rank 0 is the most recently
// touched voice and the voice holding rank VOICES-1 is the steal victim.
module voice_lru #(
  parameter  int VOICES = 4,
  localparam int IW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          touch,
  input  logic [IW-1:0] idx,
  output logic [IW-1:0] victim
);

  logic [IW-1:0] rank_q [VOICES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) rank_q[i] <= IW'(VOICES - 1 - i);
    end else if (ce && touch) begin
      for (int i = 0; i < VOICES; i++) begin
        if (IW'(i) == idx)
          rank_q[i] <= '0;
        else if (rank_q[i] < rank_q[idx])
          rank_q[i] <= rank_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int i = 0; i < VOICES; i++)
      if (rank_q[i] == IW'(VOICES - 1)) victim = IW'(i);
  end

endmodule

// File: rtl/midi_poly.sv
// Polyphonic MIDI channel-message parser with running status, voice
// allocation (retrigger / first free / LRU steal) and shared program number.
module midi_poly
  import midi_poly_pkg::*;
#(
  parameter int VOICES  = 4,
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic [7:0]            DATA,
  input  logic                  DV,
  output logic [7*VOICES-1:0]   NOTE_NUM,
  output logic [7*VOICES-1:0]   NOTE_VEL,
  output logic [VOICES-1:0]     GATE,
  output logic [6:0]            PROGRAM,
  output logic                  STOLE
);

  localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

  parse_state_t state_q, state_nx;
  logic         rs_vld_q, rs_vld_nx;
  logic [3:0]   rs_stat_q, rs_stat_nx;
  logic         rs_skip_q, rs_skip_nx;
  logic [6:0]   d1_q, d1_nx;

  logic         vld_p0;
  logic [3:0]   stat_p0;
  logic [6:0]   k_p0, v_p0;
  logic         note_on_p0, note_off_p0, all_off_p0, prog_p0;

  logic [6:0]        note_p1 [VOICES];
  logic [6:0]        vel_p1  [VOICES];
  logic [VOICES-1:0] gate_p1;
  logic [6:0]        prog_p1;
  logic              stole_p1;

  logic          match_hit, free_hit, steal;
  logic [IW-1:0] match_idx, free_idx, tgt_idx, victim;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      rs_vld_q  <= 1'b0;
      rs_stat_q <= 4'h0;
      rs_skip_q <= 1'b0;
      d1_q      <= 7'd0;
    end else begin
      state_q   <= state_nx;
      rs_vld_q  <= rs_vld_nx;
      rs_stat_q <= rs_stat_nx;
      rs_skip_q <= rs_skip_nx;
      d1_q      <= d1_nx;
    end
  end

  // Next-state: a data byte in IDLE with valid running status acts as the first data byte.
  always_comb begin
    state_nx   = state_q;
    rs_vld_nx  = rs_vld_q;
    rs_stat_nx = rs_stat_q;
    rs_skip_nx = rs_skip_q;
    d1_nx      = d1_q;
    vld_p0     = 1'b0;
    stat_p0    = rs_stat_q;
    k_p0       = d1_q;
    v_p0       = DATA[6:0];
    if (CE && DV) begin
      if (DATA[7]) begin
        if (DATA[7:4] == 4'hF) begin
          if (!DATA[3]) begin
            state_nx  = IDLE;
            rs_vld_nx = 1'b0;
          end
        end else begin
          state_nx   = D1;
          rs_vld_nx  = 1'b1;
          rs_stat_nx = DATA[7:4];
          rs_skip_nx = !OMNI && (DATA[3:0] != 4'(CHANNEL));
        end
      end else if (state_q == D2) begin
        state_nx = IDLE;
        vld_p0   = !rs_skip_q;
      end else if (state_q == D1 || rs_vld_q) begin
        if (msg_len(rs_stat_q) == 2'd1) begin
          state_nx = IDLE;
          vld_p0   = !rs_skip_q;
          k_p0     = DATA[6:0];
        end else begin
          state_nx = D2;
          d1_nx    = DATA[6:0];
        end
      end
    end
  end

  always_comb begin
    note_on_p0  = vld_p0 && stat_p0 == NOTE_ON && v_p0 != 7'd0;
    note_off_p0 = vld_p0 && (stat_p0 == NOTE_OFF || (stat_p0 == NOTE_ON && v_p0 == 7'd0));
    all_off_p0  = vld_p0 && stat_p0 == CC &&
                  (k_p0 == CC_ALL_SOUND_OFF || k_p0 == CC_ALL_NOTES_OFF);
    prog_p0     = vld_p0 && stat_p0 == PROG;
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (gate_p1[i] && note_p1[i] == k_p0) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
      if (!gate_p1[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    tgt_idx = victim;
    steal   = 1'b0;
    if (match_hit)     tgt_idx = match_idx;
    else if (free_hit) tgt_idx = free_idx;
    else               steal   = 1'b1;
  end

  voice_lru #(.VOICES(VOICES)) u_lru (
    .clk    (CLK),
    .rst    (RST),
    .ce     (CE),
    .touch  (note_on_p0),
    .idx    (tgt_idx),
    .victim (victim)
  );

  // ---- stage p1: registered voice outputs ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < VOICES; i++) begin
        note_p1[i] <= 7'd0;
        vel_p1[i]  <= 7'd0;
      end
      gate_p1  <= '0;
      prog_p1  <= 7'd0;
      stole_p1 <= 1'b0;
    end else if (CE) begin
      stole_p1 <= note_on_p0 && steal;
      if (note_on_p0) begin
        note_p1[tgt_idx] <= k_p0;
        vel_p1[tgt_idx]  <= v_p0;
        gate_p1[tgt_idx] <= 1'b1;
      end
      if (note_off_p0 && match_hit) gate_p1[match_idx] <= 1'b0;
      if (all_off_p0) gate_p1 <= '0;
      if (prog_p0) prog_p1 <= k_p0;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_pack
    assign NOTE_NUM[7*g +: 7] = note_p1[g];
    assign NOTE_VEL[7*g +: 7] = vel_p1[g];
  end

  assign GATE    = gate_p1;
  assign PROGRAM = prog_p1;
  assign STOLE   = stole_p1;

endmodule

// File: tb/tb_midi_poly.sv
// Scoreboard bench for midi_poly: a queue-and-list reference model predicts
// the full output state after every accepted byte or reset cycle.
module tb_midi_poly;

  localparam int VOICES  = 4;
  localparam int CHANNEL = 0;
  localparam int SW      = 14 * VOICES + VOICES + 8;

  logic                CLK = 1'b0;
  logic                RST, CE, DV;
  logic [7:0]          DATA;
  logic [7*VOICES-1:0] NOTE_NUM, NOTE_VEL;
  logic [VOICES-1:0]   GATE;
  logic [6:0]          PROGRAM;
  logic                STOLE;

  midi_poly #(.VOICES(VOICES), .CHANNEL(CHANNEL), .OMNI(1'b0)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .DATA(DATA), .DV(DV),
    .NOTE_NUM(NOTE_NUM), .NOTE_VEL(NOTE_VEL), .GATE(GATE),
    .PROGRAM(PROGRAM), .STOLE(STOLE)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SW-1:0] exp_q [$];
  string         tag_q [$];
  string         cur_tag = "init";

  // Reference model: voice arrays, recency list (front = most recent), byte buffer.
  int m_note [VOICES];
  int m_vel  [VOICES];
  bit m_gate [VOICES];
  int m_prog;
  bit m_stole;
  int lru [$];
  int rs;
  int buf_q [$];

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_note[i] = 0; m_vel[i] = 0; m_gate[i] = 0;
    end
    m_prog = 0; m_stole = 0; rs = -1;
    buf_q.delete();
    lru.delete();
    for (int i = VOICES - 1; i >= 0; i--) lru.push_back(i);
  endfunction

  function automatic void touch(input int v);
    for (int j = 0; j < lru.size(); j++)
      if (lru[j] == v) begin lru.delete(j); break; end
    lru.push_front(v);
  endfunction

  function automatic void apply(input int hi, input int a, input int b);
    int tgt;
    if (hi == 9 && b != 0) begin
      tgt = -1;
      for (int i = 0; i < VOICES; i++) if (tgt < 0 && m_gate[i] && m_note[i] == a) tgt = i;
      for (int i = 0; i < VOICES; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
      if (tgt < 0) begin tgt = lru[$]; m_stole = 1; end
      m_note[tgt] = a; m_vel[tgt] = b; m_gate[tgt] = 1;
      touch(tgt);
    end else if (hi == 8 || hi == 9) begin
      for (int i = 0; i < VOICES; i++) if (m_gate[i] && m_note[i] == a) m_gate[i] = 0;
    end else if (hi == 11 && (a == 120 || a == 123)) begin
      for (int i = 0; i < VOICES; i++) m_gate[i] = 0;
    end else if (hi == 12) begin
      m_prog = a;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int bi, need;
    bi = int'(b);
    m_stole = 0;
    if (bi >= 'hF8) return;
    if (bi >= 'hF0) begin rs = -1; buf_q.delete(); return; end
    if (bi >= 'h80) begin rs = bi; buf_q.delete(); return; end
    if (rs < 0) return;
    buf_q.push_back(bi);
    need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
    if (buf_q.size() == need) begin
      if ((rs & 15) == CHANNEL) apply(rs >> 4, buf_q[0], (need == 2) ? buf_q[1] : 0);
      buf_q.delete();
    end
  endfunction

  function automatic logic [SW-1:0] snap_model();
    logic [7*VOICES-1:0] nn, nv;
    logic [VOICES-1:0]   g;
    for (int i = 0; i < VOICES; i++) begin
      nn[7*i +: 7] = 7'(m_note[i]);
      nv[7*i +: 7] = 7'(m_vel[i]);
      g[i]         = m_gate[i];
    end
    return {nn, nv, g, 7'(m_prog), m_stole};
  endfunction

  function automatic void push_exp();
    exp_q.push_back(snap_model());
    tag_q.push_back(cur_tag);
  endfunction

  // Monitor: the DUT presents a new output state after each accepted byte or reset cycle.
  logic evt = 1'b0;
  always @(posedge CLK) evt <= RST || (CE && DV);

  always @(negedge CLK) begin
    if (evt) begin
      logic [SW-1:0] act, e;
      string t;
      act = {NOTE_NUM, NOTE_VEL, GATE, PROGRAM, STOLE};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty got=%h required=<queued entry>", act);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s got=%h required=%h", t, act, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic ce_v = 1'b1);
    DATA = b; DV = 1'b1; CE = ce_v;
    if (ce_v) begin model_byte(b); push_exp(); end
    @(posedge CLK); #1;
    DV = 1'b0; CE = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1; DV = 1'b0;
    model_reset();
    push_exp();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  logic [7:0] stat_tab [10] = '{8'h80, 8'h90, 8'h90, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hA0, 8'h91, 8'h81};

  initial begin
    RST = 1'b1; CE = 1'b1; DV = 1'b0; DATA = 8'h00;
    cur_tag = "reset";
    do_reset();
    chk("reset_gate", 32'(GATE), 32'h0);
    chk("reset_note", 32'(NOTE_NUM), 32'h0);

    cur_tag = "t1_note_on";
    send(8'h90); send(8'h3C); send(8'h40);
    chk("t1_note0", 32'(NOTE_NUM[6:0]), 32'h3C);
    chk("t1_vel0", 32'(NOTE_VEL[6:0]), 32'h40);
    chk("t1_gate", 32'(GATE), 32'h1);
    chk("t1_prog", 32'(PROGRAM), 32'h0);

    cur_tag = "t2_running";
    do_reset();
    foreach (stat_tab[i]) if (i < 0) send(8'h00);
    send(8'h90); send(8'h3C); send(8'h40); send(8'h3E); send(8'h50);
    send(8'h40); send(8'h60); send(8'h3C); send(8'h00);
    chk("t2_gate", 32'(GATE), 32'h6);
    chk("t2_note0_kept", 32'(NOTE_NUM[6:0]), 32'h3C);

    cur_tag = "t3_steal";
    do_reset();
    send(8'h90);
    for (int k = 60; k <= 64; k++) begin send(8'(k)); send(8'h40); end
    chk("t3_stole", 32'(STOLE), 32'h1);
    chk("t3_note0", 32'(NOTE_NUM[6:0]), 32'd64);
    send(8'd61); send(8'h7F);
    chk("t3_retrig_stole", 32'(STOLE), 32'h0);
    chk("t3_retrig_vel1", 32'(NOTE_VEL[13:7]), 32'h7F);

    cur_tag = "t4_channel_rt";
    do_reset();
    send(8'h91); send(8'h3C); send(8'h40);
    chk("t4_other_chan", 32'(GATE), 32'h0);
    send(8'hC0); send(8'hF8); send(8'h05);
    chk("t4_prog", 32'(PROGRAM), 32'h5);

    cur_tag = "t5_syscommon";
    do_reset();
    send(8'h90); send(8'h3C); send(8'h40); send(8'hF0); send(8'h3E); send(8'h40);
    chk("t5_gate", 32'(GATE), 32'h1);
    send(8'hB0); send(8'h7B); send(8'h00);
    chk("t5_all_off", 32'(GATE), 32'h0);

    cur_tag = "t6_reset_mid";
    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h40);
    chk("t6_gate", 32'(GATE), 32'h0);
    cur_tag = "t6_ce_block";
    send(8'h90); send(8'h3C, 1'b0); send(8'h3E); send(8'h40);
    chk("t6_ce_note0", 32'(NOTE_NUM[6:0]), 32'h3E);

    cur_tag = "random";
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 12)       send(stat_tab[$urandom_range(0, 9)]);
      else if (r < 15)  send(($urandom_range(0, 1) != 0) ? 8'hF8 : 8'hFE);
      else if (r < 17)  send(8'hF0 + 8'($urandom_range(0, 7)));
      else if (r < 19)  do_reset();
      else if (r < 22)  send(8'd123);
      else if (r < 24)  send(8'd120);
      else if (r < 30)  send(8'h00, ($urandom_range(0, 1) != 0));
      else              send(8'(60 + $urandom_range(0, 6)), ($urandom_range(0, 9) != 0));
    end

    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
